// File: rtl/player_ctrl.sv
// player_ctrl: debounces four pushbuttons and moves a 4x4 grid cursor once per frame.
// Define PLAYER_WRAP_EN to wrap off-grid moves instead of clamping them.
module player_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter logic [3:0] INIT_ADDR       = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] player_address,
  output logic       move_strobe
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  // bit order: 0 up, 1 down, 2 left, 3 right (also priority order)
  logic [3:0]    raw;
  logic [3:0]    s1_q;
  logic [3:0]    s2_q;
  logic [3:0]    deb_q;
  logic [3:0]    deb_d;
  logic [3:0]    press;
  logic [3:0]    pend_q;
  logic [3:0]    pend_d;
  logic [3:0]    grant;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic          vsync_q;
  logic          tick;
  logic [3:0]    addr_q;
  logic [3:0]    addr_d;
  logic          strobe_q;
  logic          move;
  logic          legal;
  logic [1:0]    row;
  logic [1:0]    col;
  logic [1:0]    row_n;
  logic [1:0]    col_n;

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      deb_d[i] = deb_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign press = deb_q & ~deb_d;

  assign tick = vsync_q & ~vsync;

  // a press landing on the tick cycle survives the clear
  assign pend_d = (tick ? 4'b0000 : pend_q) | press;

  assign grant = pend_q & (~pend_q + 4'd1);

  assign row = addr_q[3:2];
  assign col = addr_q[1:0];

  always_comb begin
    row_n = row;
    col_n = col;
    unique case (1'b1)
      grant[0]: row_n = row - 2'd1;
      grant[1]: row_n = row + 2'd1;
      grant[2]: col_n = col - 2'd1;
      grant[3]: col_n = col + 2'd1;
      default:  ;
    endcase
  end

`ifdef PLAYER_WRAP_EN
  assign legal = 1'b1;
`else
  logic edge_hit;

  always_comb begin
    unique case (1'b1)
      grant[0]: edge_hit = (row == 2'd0);
      grant[1]: edge_hit = (row == 2'd3);
      grant[2]: edge_hit = (col == 2'd0);
      grant[3]: edge_hit = (col == 2'd3);
      default:  edge_hit = 1'b0;
    endcase
  end

  assign legal = ~edge_hit;
`endif

  assign move   = tick & (|pend_q) & legal;
  assign addr_d = move ? {row_n, col_n} : addr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= 4'b1111;
      s2_q     <= 4'b1111;
      deb_q    <= 4'b1111;
      pend_q   <= 4'b0000;
      vsync_q  <= 1'b1;
      addr_q   <= INIT_ADDR;
      strobe_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      deb_q    <= deb_d;
      pend_q   <= pend_d;
      vsync_q  <= vsync;
      addr_q   <= addr_d;
      strobe_q <= move;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign player_address = addr_q;
  assign move_strobe    = strobe_q;

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Upstream of the renderer. Converts four raw pushbuttons into the 4-bit player cell address the renderer consumes.
- Playfield is a 4x4 grid; address = row*4 + col, with row 0 at the top.
- Runs on the 25 MHz pixel clock and samples the synchronizer's vsync. The address changes only at frame start, so a frame never shows a torn sprite.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button level change (10 ms at 25 MHz). Minimum 2.
- INIT_ADDR, 4'd0, player address after reset.

Ports:
- clk  input  1  pixel clock (25 MHz).
- rst  input  1  asynchronous, active-low reset.
- vsync  input  1  active-low vertical sync from the synchronizer, same clock domain.
- btn_up  input  1  raw pushbutton, active-low, asynchronous.
- btn_down  input  1  raw pushbutton, active-low, asynchronous.
- btn_left  input  1  raw pushbutton, active-low, asynchronous.
- btn_right  input  1  raw pushbutton, active-low, asynchronous.
- player_address  output  4  current player cell, {row[1:0], col[1:0]}.
- move_strobe  output  1  one-cycle pulse in the cycle player_address takes a new value.

Behaviour:
- Reset (rst=0, asynchronous):
  - player_address=INIT_ADDR, move_strobe=0.
  - All synchronizer flops and debounced states = released (1).
  - Debounce counters=0, pending flags=0, vsync_q=1.
- Input sync: each button passes through a 2-flop synchronizer before debouncing.
- Debounce, per button:
  - Counter resets to 0 whenever the synced level equals the debounced state.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced state takes the synced level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Press edge: debounced state goes released->pressed (1->0). This sets that button's pending flag.
  - Release sets nothing.
  - Holding a button yields exactly one move; there is no autorepeat.
- Frame tick:
  - vsync_q <= vsync every cycle.
  - tick = vsync_q & ~vsync, i.e. the first low cycle of the vsync pulse. Exactly one tick per frame.
- Apply, on the clock edge ending the tick cycle:
  - Select the highest-priority pending flag, priority up > down > left > right.
  - Compute the target: up row-1, down row+1, left col-1, right col+1.
  - Legal target: player_address <= target and move_strobe=1 for the next cycle only.
  - Target off-grid (row 0 up, row 3 down, col 0 left, col 3 right): address unchanged, move_strobe stays 0 (clamp).
  - All pending flags clear on every tick, including lower-priority ones, which are discarded.
  - No tick: address held, move_strobe=0.
- Simultaneous events: a press edge in the same cycle as tick is not applied on that tick. It stays pending for the next frame, so a set beats the tick's clear for that bit only.
- Latency, button fall to address change: 2 (sync) + DEBOUNCE_CYCLES cycles to set pending, then up to one frame (420000 cycles at 640x480) to the next tick, then 1 cycle.
- Mid-operation reset: everything returns to its reset values. A button held through reset release is treated as a new press once debounced.
- Arithmetic: row and col are 2-bit fields. Legality is checked before the add/subtract, so no carry into the other field.

Optional Feature:
- Macro: PLAYER_WRAP_EN.
- Defined: off-grid moves wrap within the same row or column, modulo 4, with move_strobe=1.
  - Example: address 4'd3 (row 0, col 3) + right -> 4'd0.
  - Example: address 4'd1 + up -> 4'd13.
- Undefined: clamp behaviour as specified above.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4, short synthetic vsync period of 100 cycles with 2-cycle low pulse.
- Reset: rst=0 for 3 cycles, then 1 -> player_address=0, move_strobe=0. Assert rst=0 asynchronously mid-frame -> outputs reset in the same cycle, no clock needed.
- Debounce: btn_right low for 3 cycles then high -> no pending, address stays 0. btn_right low for 10 cycles -> after next tick player_address=1, move_strobe high for exactly 1 cycle.
- Hold: btn_down held low for 5 frames from address 1 -> exactly one move, to address 5. Release, press again -> address 9 after next tick.
- Priority/discard: press btn_left and btn_up in the same frame at address 5 -> next tick address 1 (up wins). Following tick -> no move (left discarded).
- Clamp: address 0, press btn_up -> after tick address 0, move_strobe never asserts. With PLAYER_WRAP_EN: address 12, press down -> address 0, strobe asserts.
- Tick collision: align the debounced press edge of btn_right with the tick cycle at address 0 -> no move on that tick. address=1 after the following tick.
